// File: rtl/mcb_port_responder.sv
// MCB port-0 responder: on-chip 128-bit RAM behind a command, write and read FIFO.
// Optional random beat stalls when MCB_RESP_STALL_EN is defined.
module mcb_port_responder #(
  parameter int MEM_AW       = 10,
  parameter int DATA_FIFO_AW = 6,
  parameter int CMD_FIFO_AW  = 2,
  parameter int CALIB_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    calib_done,
  input  logic                    p0_cmd_en,
  input  logic [2:0]              p0_cmd_instr,
  input  logic [29:0]             p0_cmd_byte_addr,
  input  logic [5:0]              p0_cmd_bl,
  output logic                    p0_cmd_full,
  input  logic                    p0_wr_en,
  input  logic [127:0]            p0_wr_data,
  input  logic [15:0]             p0_wr_mask,
  output logic                    p0_wr_full,
  output logic                    p0_wr_empty,
  output logic [DATA_FIFO_AW:0]   p0_wr_count,
  output logic                    p0_wr_underrun,
  input  logic                    p0_rd_en,
  output logic [127:0]            p0_rd_data,
  output logic                    p0_rd_empty,
  output logic [DATA_FIFO_AW:0]   p0_rd_count,
  output logic [2:0]              err_flags
);

  localparam int DAW    = DATA_FIFO_AW;
  localparam int CAW    = CMD_FIFO_AW;
  localparam int DDEPTH = 1 << DAW;
  localparam int CDEPTH = 1 << CAW;
  localparam int CW     = 3 + MEM_AW + 6;
  localparam int CALW   = $clog2(CALIB_CYCLES + 1);

  typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WRITE, S_READ} state_t;

  state_t              state_q, state_d;
  logic [CALW-1:0]     cal_q;
  logic                calib_q;
  logic [5:0]          beat_q, beat_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;

  logic [CW-1:0]       cmd_mem [CDEPTH];
  logic [CAW-1:0]      cwp_q, crp_q;
  logic [CAW:0]        ccnt_q;
  logic [143:0]        wmem [DDEPTH];
  logic [DAW-1:0]      wwp_q, wrp_q;
  logic [DAW:0]        wcnt_q;
  logic [127:0]        rmem [DDEPTH];
  logic [DAW-1:0]      rwp_q, rrp_q;
  logic [DAW:0]        rcnt_q;
  logic [127:0]        mem [1 << MEM_AW];
  logic [127:0]        ram_q;
  logic                pend_q;
  logic [127:0]        rd_data_q;
  logic [2:0]          err_q;

  logic cmd_full, cmd_push, cmd_pop;
  logic wr_full, wr_push, wr_pop;
  logic rd_pop, rd_space, mem_we, ram_re, underrun, stall;
  logic [CW-1:0]     c_head;
  logic [2:0]        c_instr;
  logic [MEM_AW-1:0] c_addr;
  logic [5:0]        c_bl;
  logic [143:0]      w_head;
  logic [DAW+1:0]    rd_occ;
  logic              unused_bits;

`ifdef MCB_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign cmd_full = !calib_q || (ccnt_q == (CAW+1)'(CDEPTH));
  assign wr_full  = !calib_q || (wcnt_q == (DAW+1)'(DDEPTH));
  assign cmd_push = p0_cmd_en && !cmd_full;
  assign wr_push  = p0_wr_en && !wr_full;
  assign rd_pop   = p0_rd_en && (rcnt_q != '0);

  assign c_head  = cmd_mem[crp_q];
  assign c_instr = c_head[CW-1 -: 3];
  assign c_addr  = c_head[6 +: MEM_AW];
  assign c_bl    = c_head[5:0];
  assign w_head  = wmem[wrp_q];

  // In-flight RAM read counts against read FIFO space so a push never overflows
  assign rd_occ   = {1'b0, rcnt_q} + {{(DAW+1){1'b0}}, pend_q};
  assign rd_space = rd_occ < (DAW+2)'(DDEPTH);

  assign unused_bits = ^{p0_cmd_byte_addr[29:MEM_AW+4],
                         p0_cmd_byte_addr[3:0], c_instr[1]};

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    cmd_pop  = 1'b0;
    wr_pop   = 1'b0;
    mem_we   = 1'b0;
    ram_re   = 1'b0;
    underrun = 1'b0;
    unique case (state_q)
      S_CALIB: begin
        if (cal_q == CALW'(CALIB_CYCLES - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ccnt_q != '0) begin
          cmd_pop = 1'b1;
          beat_d  = c_bl;
          addr_d  = c_addr;
          if (!c_instr[2] && !c_instr[0]) state_d = S_WRITE;
          else if (!c_instr[2] && c_instr[0]) state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (!stall) begin
          if (wcnt_q == '0) begin
            underrun = 1'b1;
          end else begin
            wr_pop = 1'b1;
            mem_we = 1'b1;
            addr_d = addr_q + MEM_AW'(1);
            if (beat_q == 6'd0) state_d = S_IDLE;
            else beat_d = beat_q - 6'd1;
          end
        end
      end
      S_READ: begin
        if (!stall && rd_space) begin
          ram_re = 1'b1;
          addr_d = addr_q + MEM_AW'(1);
          if (beat_q == 6'd0) state_d = S_IDLE;
          else beat_d = beat_q - 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CALIB;
      cal_q     <= '0;
      calib_q   <= 1'b0;
      beat_q    <= '0;
      addr_q    <= '0;
      cwp_q     <= '0;
      crp_q     <= '0;
      ccnt_q    <= '0;
      wwp_q     <= '0;
      wrp_q     <= '0;
      wcnt_q    <= '0;
      rwp_q     <= '0;
      rrp_q     <= '0;
      rcnt_q    <= '0;
      pend_q    <= 1'b0;
      rd_data_q <= '0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      pend_q  <= ram_re;
      if (state_q == S_CALIB) cal_q <= cal_q + CALW'(1);
      if (state_q == S_CALIB && state_d == S_IDLE) calib_q <= 1'b1;
      if (cmd_push) cwp_q <= cwp_q + CAW'(1);
      if (cmd_pop)  crp_q <= crp_q + CAW'(1);
      if (cmd_push && !cmd_pop) ccnt_q <= ccnt_q + (CAW+1)'(1);
      else if (!cmd_push && cmd_pop) ccnt_q <= ccnt_q - (CAW+1)'(1);
      if (wr_push) wwp_q <= wwp_q + DAW'(1);
      if (wr_pop)  wrp_q <= wrp_q + DAW'(1);
      if (wr_push && !wr_pop) wcnt_q <= wcnt_q + (DAW+1)'(1);
      else if (!wr_push && wr_pop) wcnt_q <= wcnt_q - (DAW+1)'(1);
      if (pend_q) rwp_q <= rwp_q + DAW'(1);
      if (rd_pop) rrp_q <= rrp_q + DAW'(1);
      if (pend_q && !rd_pop) rcnt_q <= rcnt_q + (DAW+1)'(1);
      else if (!pend_q && rd_pop) rcnt_q <= rcnt_q - (DAW+1)'(1);
      if (rd_pop) rd_data_q <= rmem[rrp_q];
      err_q <= err_q | {p0_rd_en && (rcnt_q == '0),
                        p0_wr_en && wr_full,
                        p0_cmd_en && cmd_full};
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cwp_q] <= {p0_cmd_instr, p0_cmd_byte_addr[MEM_AW+3:4], p0_cmd_bl};
    if (wr_push) wmem[wwp_q] <= {p0_wr_mask, p0_wr_data};
    if (pend_q)  rmem[rwp_q] <= ram_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 16; b++)
        if (!w_head[128 + b]) mem[addr_q][b*8 +: 8] <= w_head[b*8 +: 8];
    end
    if (ram_re) ram_q <= mem[addr_q];
  end

  assign calib_done     = calib_q;
  assign p0_cmd_full    = cmd_full;
  assign p0_wr_full     = wr_full;
  assign p0_wr_empty    = (wcnt_q == '0);
  assign p0_wr_count    = wcnt_q;
  assign p0_wr_underrun = underrun;
  assign p0_rd_data     = rd_data_q;
  assign p0_rd_empty    = (rcnt_q == '0);
  assign p0_rd_count    = rcnt_q;
  assign err_flags      = err_q;

endmodule

// File: doc/mcb_port_responder.md
Name: mcb_port_responder

Overview:
- Synthesizable responder for one MCB user port (port 0) with on-chip 128-bit block RAM behind it.
- Accepts commands, write data and read requests on the same p0_* signals that our MCB controllers drive, and services them from internal memory.
- Used for DRAM-less loopback on the XEM6310 and as the DUT-side model in controller benches.

Parameters:
- MEM_AW, 10, log2 of memory depth in 128-bit words (1024 words = 16 KB).
- DATA_FIFO_AW, 6, log2 of write and read data FIFO depth (64 words).
- CMD_FIFO_AW, 2, log2 of command FIFO depth (4 entries).
- CALIB_CYCLES, 64, clocks after reset release before calib_done rises.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- calib_done  out  1  memory ready.
- p0_cmd_en  in  1  command strobe.
- p0_cmd_instr  in  3  000/010 = write, 001/011 = read, others = no-op.
- p0_cmd_byte_addr  in  30  byte address.
- p0_cmd_bl  in  6  beats minus 1.
- p0_cmd_full  out  1  command FIFO full.
- p0_wr_en  in  1  write data push.
- p0_wr_data  in  128  write word.
- p0_wr_mask  in  16  1 = byte not written.
- p0_wr_full  out  1  write FIFO full.
- p0_wr_empty  out  1  write FIFO empty.
- p0_wr_count  out  7  write FIFO occupancy.
- p0_wr_underrun  out  1  single-cycle pulse when a write beat stalls on an empty FIFO.
- p0_rd_en  in  1  read data pop.
- p0_rd_data  out  128  registered read word.
- p0_rd_empty  out  1  read FIFO empty.
- p0_rd_count  out  7  read FIFO occupancy.
- err_flags  out  3  sticky errors: {rd_en while empty, wr_en while full, cmd_en while full}.

Behaviour:
- Reset (async assert, sync release):
  - all FIFOs flushed; FSM to CALIB.
  - calib_done = 0; p0_cmd_full = 1; p0_wr_full = 1; p0_wr_empty = 1; p0_rd_empty = 1.
  - counts = 0; p0_rd_data = 0; p0_wr_underrun = 0; err_flags = 0.
  - Memory contents are not cleared; reset mid-command aborts the command with no further memory writes.
- CALIB: counts CALIB_CYCLES clocks, then sets calib_done = 1 (stays high until reset) and goes to IDLE.
  - p0_cmd_full and p0_wr_full are forced 1 while calib_done = 0; pushes in that window are dropped and set the matching error flag.
- Command FIFO:
  - Entry = {instr, word address = byte_addr[MEM_AW+3:4], bl}; byte_addr[3:0] is ignored.
  - A push while full is dropped and sets err_flags[0].
- IDLE: pops one command when the FIFO is non-empty; beat counter = bl, address register = word address.
  - write -> WRITE; read -> READ; no-op -> discarded, stay in IDLE.
  - Pop-to-first-beat is 1 cycle.
- WRITE: each cycle with the write FIFO non-empty, pop one word and write it at the current address with byte enables = ~mask.
  - Address increments modulo 2^MEM_AW (wraps to 0).
  - Write FIFO empty -> stall; p0_wr_underrun = 1 that cycle.
  - Last beat (counter = 0) -> IDLE.
- READ: each cycle with read FIFO space (count + in-flight < depth), issue a RAM read.
  - RAM latency is 1 cycle; the result is pushed into the read FIFO the next cycle.
  - Address wraps as in WRITE. Read FIFO full -> stall, no overflow possible.
  - Go to IDLE after the last beat is issued; the pending push completes in IDLE.
- Write FIFO:
  - A push while full is dropped and sets err_flags[1].
  - Push and pop in the same cycle leave the count unchanged.
  - p0_wr_full = (count == 2^DATA_FIFO_AW).
- Read port:
  - p0_rd_en with non-empty FIFO: p0_rd_data updates on the next clock edge and holds until the next accepted pop.
  - p0_rd_en while empty is ignored and sets err_flags[2].
- Commands execute strictly in order; a read following a write to the same address returns the newly written data.
- Commands may be queued before their write data arrives.

Optional Feature:
- Macro: MCB_RESP_STALL_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every clock.
  - Any WRITE or READ beat is withheld in a cycle where LFSR[1:0] == 2'b00 (~25% random stall); p0_wr_underrun is not asserted for these stalls.
- Undefined: no LFSR logic; beats proceed whenever FIFO conditions allow.

Test Plan:
- Reset, then idle 70 clocks -> calib_done rises at cycle 64; cmd_full/wr_full go 1->0 on the same cycle.
- Push 8 words 0x0..0x7, write cmd at addr 0x0, bl=7; then read cmd at 0x0, bl=7; pop 8 -> rd_data = 0x0..0x7 in order, err_flags = 0.
- Write addr 0x3FF0 (word 1023), bl=1, data A/B -> A at word 1023, B at word 0; readback at 0x3FF0 returns A, B.
- Write cmd bl=3 with only 2 words pushed -> 2 beats written, p0_wr_underrun pulses each stalled cycle, finishes after words 3-4 are pushed.
- Mask 16'h00FF on data all-ones over a zeroed word -> readback 0xFF..FF_00..00 (upper 8 bytes written).
- Read bl=63 twice without popping -> rd_count saturates at 64, FSM stalls; drain -> second command completes; rd_en on empty sets err_flags[2].
